jtkcpu_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit for the KCPU execution stage. It performs unsigned or signed W×W→2W multiplication and 2W÷W→W division, one radix-2 step per enabled clock. It uses a start/busy/done handshake so the sequencer can stall on `busy`. It generalises the fixed 16÷8 divider used by the ALU for DIV_X_B and the combinational MUL/LMUL paths, and adds signed multiply, a width parameter, and result flags.

---
 rtl/jtkcpu_muldiv.sv | 277 +++++++++++++++++++++++++++
 tb/tb_jtkcpu_muldiv.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : jtkcpu_muldiv                                              |
// | Description : Iterative W x W -> 2W multiply and 2W / W -> W divide,     |
// |               one radix-2 step per enabled clock, start/busy/done        |
// |               handshake, V/Z/N result flags.                             |
// |               Define JTKCPU_MULDIV_SIGN_EN to honour the sign input      |
// |               (two's-complement operands); otherwise all operations are  |
// |               unsigned with identical latency.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module jtkcpu_muldiv #(
  parameter int W = 16
) (
  input  logic           rst,
  input  logic           clk,
  input  logic           cen,
  input  logic           start,
  input  logic           op,
  input  logic           sign,
  input  logic [2*W-1:0] a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   rslt_lo,
  output logic [W-1:0]   rslt_hi,
  output logic           v,
  output logic           z,
  output logic           n
);

  localparam int            CW        = $clog2(W);
  // ITER holds W-1 steps; the W-th step is taken on the FIX edge so that the
  // results land W+1 enabled edges after the start is accepted.
  localparam logic [CW-1:0] ITER_LAST = CW'(W - 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_q, op_d;
  logic [W-1:0]  work_hi_q, work_hi_d;   // product high / partial remainder
  logic [W-1:0]  work_lo_q, work_lo_d;   // multiplier / dividend low, quotient
  logic [W-1:0]  dvs_q, dvs_d;           // multiplicand or divisor magnitude
  logic [W-1:0]  alo_q, alo_d;           // raw a[W-1:0] for the overflow result
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic [W-1:0]  lo_q, lo_d, hi_q, hi_d;
  logic          v_q, v_d, z_q, z_d, n_q, n_d;

`ifdef JTKCPU_MULDIV_SIGN_EN
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};
  logic sign_q, sign_d;
  logic qneg_q, qneg_d;                  // product / quotient is negative
  logic rneg_q, rneg_d;                  // remainder is negative
  logic sgn_a, sgn_b;
`else
  logic unused_sign;
  assign unused_sign = sign;
`endif

  logic [W:0]     mul_sum, div_t;
  logic [W-1:0]   div_diff, step_hi, step_lo;
  logic           div_ge;
  logic [2*W-1:0] mag_a;
  logic [W-1:0]   mag_alo, mag_b;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem;
  logic           div_ovf;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state_q <= S_IDLE;
    else if (cen) state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = S_ITER;
      S_ITER:  if (cnt_q == ITER_LAST) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // One radix-2 step: shift-add for multiply, restoring step for divide
  always_comb begin
    mul_sum  = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, dvs_q} : '0);
    div_t    = {work_hi_q, work_lo_q[W-1]};
    div_ge   = (div_t >= {1'b0, dvs_q});
    // Without overflow the partial remainder stays below the divisor, so the
    // W-bit difference is exact whenever it is used.
    div_diff = div_t[W-1:0] - dvs_q;
    if (op_q) begin
      step_hi = div_ge ? div_diff : div_t[W-1:0];
      step_lo = {work_lo_q[W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], work_lo_q[W-1:1]};
    end
  end

  // Operand magnitudes taken in LOAD
  always_comb begin
`ifdef JTKCPU_MULDIV_SIGN_EN
    sgn_a   = sign_q & (op_q ? work_hi_q[W-1] : work_lo_q[W-1]);
    sgn_b   = sign_q & dvs_q[W-1];
    mag_a   = sgn_a ? -{work_hi_q, work_lo_q} : {work_hi_q, work_lo_q};
    mag_alo = sgn_a ? -work_lo_q : work_lo_q;
    mag_b   = sgn_b ? -dvs_q : dvs_q;
`else
    mag_a   = {work_hi_q, work_lo_q};
    mag_alo = work_lo_q;
    mag_b   = dvs_q;
`endif
  end

  // Sign correction and overflow decision applied in FIX
  always_comb begin
`ifdef JTKCPU_MULDIV_SIGN_EN
    prod    = qneg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    quo     = qneg_q ? -step_lo : step_lo;
    rem     = rneg_q ? -step_hi : step_hi;
    div_ovf = ovf_q | (sign_q & (qneg_q ? (step_lo > HALF) : step_lo[W-1]));
`else
    prod    = {step_hi, step_lo};
    quo     = step_lo;
    rem     = step_hi;
    div_ovf = ovf_q;
`endif
  end

  // Datapath next-state: operand capture, load, iterate, write results
  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    dvs_d     = dvs_q;
    alo_d     = alo_q;
    ovf_d     = ovf_q;
    done_d    = done_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    v_d       = v_q;
    z_d       = z_q;
    n_d       = n_q;
`ifdef JTKCPU_MULDIV_SIGN_EN
    sign_d    = sign_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
`endif
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          op_d      = op;
          work_hi_d = a[2*W-1:W];
          work_lo_d = a[W-1:0];
          dvs_d     = b;
          alo_d     = a[W-1:0];
`ifdef JTKCPU_MULDIV_SIGN_EN
          sign_d    = sign;
`endif
        end
      end
      S_LOAD: begin
        cnt_d = '0;
`ifdef JTKCPU_MULDIV_SIGN_EN
        qneg_d = sgn_a ^ sgn_b;
        rneg_d = op_q & sgn_a;
`endif
        if (op_q) begin
          {work_hi_d, work_lo_d} = mag_a;
          dvs_d = mag_b;
          // Quotient needs more than W bits (or b is zero)
          ovf_d = (mag_a[2*W-1:W] >= mag_b);
        end else begin
          work_hi_d = '0;
          work_lo_d = mag_b;
          dvs_d     = mag_alo;
          ovf_d     = 1'b0;
        end
      end
      S_ITER: begin
        work_hi_d = step_hi;
        work_lo_d = step_lo;
        cnt_d     = cnt_q + 1'b1;
      end
      S_FIX: begin
        done_d = 1'b1;
        if (op_q) begin
          if (div_ovf) begin
            lo_d = '1;
            hi_d = alo_q;
          end else begin
            lo_d = quo;
            hi_d = rem;
          end
          v_d = div_ovf;
          z_d = ~|lo_d;
          n_d = lo_d[W-1];
        end else begin
          lo_d = prod[W-1:0];
          hi_d = prod[2*W-1:W];
          v_d  = 1'b0;
          z_d  = ~|prod;
          n_d  = prod[2*W-1];
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      op_q      <= 1'b0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      dvs_q     <= '0;
      alo_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      v_q       <= 1'b0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
`ifdef JTKCPU_MULDIV_SIGN_EN
      sign_q    <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
`endif
    end else if (cen) begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      dvs_q     <= dvs_d;
      alo_q     <= alo_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      v_q       <= v_d;
      z_q       <= z_d;
      n_q       <= n_d;
`ifdef JTKCPU_MULDIV_SIGN_EN
      sign_q    <= sign_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
`endif
    end
  end

  assign done    = done_q;
  assign rslt_lo = lo_q;
  assign rslt_hi = hi_q;
  assign v       = v_q;
  assign z       = z_q;
  assign n       = n_q;

endmodule
`default_nettype wire

// File: tb/tb_jtkcpu_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_jtkcpu_muldiv                                           |
// | Description : Self-checking bench for jtkcpu_muldiv (W=8 and W=16        |
// |               instances) against an arithmetic reference model.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_jtkcpu_muldiv;

`ifdef JTKCPU_MULDIV_SIGN_EN
  localparam bit SIGN_EN = 1'b1;
`else
  localparam bit SIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic        op = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] a = '0;
  logic [15:0] b = '0;
  logic        start8 = 1'b0;
  logic        start16 = 1'b0;

  logic        busy8, done8, v8, z8, n8;
  logic [7:0]  lo8, hi8;
  logic        busy16, done16, v16, z16, n16;
  logic [15:0] lo16, hi16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtkcpu_muldiv #(.W(8)) u_dut8 (
    .rst(rst), .clk(clk), .cen(cen), .start(start8), .op(op), .sign(sign),
    .a(a[15:0]), .b(b[7:0]), .busy(busy8), .done(done8),
    .rslt_lo(lo8), .rslt_hi(hi8), .v(v8), .z(z8), .n(n8)
  );

  jtkcpu_muldiv #(.W(16)) u_dut16 (
    .rst(rst), .clk(clk), .cen(cen), .start(start16), .op(op), .sign(sign),
    .a(a), .b(b), .busy(busy16), .done(done16),
    .rslt_lo(lo16), .rslt_hi(hi16), .v(v16), .z(z16), .n(n16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input int w, input bit o, input bit sg,
                                input logic [31:0] aa, input logic [15:0] bb,
                                output logic [15:0] elo, output logic [15:0] ehi,
                                output logic ev, output logic ez, output logic en);
    longint mw, m2, sa, sb, q, r, p;
    bit s;
    s  = sg & SIGN_EN;
    mw = (longint'(1) << w) - 1;
    m2 = (longint'(1) << (2*w)) - 1;
    q  = 0;
    r  = 0;
    if (!o) begin
      sa = longint'(aa) & mw;
      sb = longint'(bb) & mw;
      if (s && sa[w-1]) sa = sa - (longint'(1) << w);
      if (s && sb[w-1]) sb = sb - (longint'(1) << w);
      p   = (sa * sb) & m2;
      ehi = 16'((p >> w) & mw);
      elo = 16'(p & mw);
      ev  = 1'b0;
      ez  = (p == 0);
      en  = ehi[w-1];
    end else begin
      sa = longint'(aa) & m2;
      sb = longint'(bb) & mw;
      if (s && sa[2*w-1]) sa = sa - (longint'(1) << (2*w));
      if (s && sb[w-1])   sb = sb - (longint'(1) << w);
      if (sb == 0) ev = 1'b1;
      else begin
        q = sa / sb;
        r = sa % sb;
        if (s) ev = (q < -(longint'(1) << (w-1))) || (q > (longint'(1) << (w-1)) - 1);
        else   ev = (q > mw);
      end
      if (ev) begin
        elo = 16'(mw);
        ehi = 16'(longint'(aa) & mw);
      end else begin
        elo = 16'(q & mw);
        ehi = 16'(r & mw);
      end
      ez = (elo == 0);
      en = elo[w-1];
    end
  endfunction

  function automatic void read_out(input int w, output logic bsy, output logic dn,
                                   output logic [15:0] lo, output logic [15:0] hi,
                                   output logic vv, output logic zz, output logic nn);
    if (w == 8) begin
      bsy = busy8; dn = done8; lo = {8'h00, lo8}; hi = {8'h00, hi8};
      vv = v8; zz = z8; nn = n8;
    end else begin
      bsy = busy16; dn = done16; lo = lo16; hi = hi16;
      vv = v16; zz = z16; nn = n16;
    end
  endfunction

  // Issue one operation (entered and left at a negedge) and check it.
  task automatic run_op(input int w, input bit o, input bit sg,
                        input logic [31:0] aa, input logic [15:0] bb,
                        input bit rnd_cen, input bit hammer);
    logic [15:0] elo, ehi, lo, hi, lo0, hi0;
    logic ev, ez, en, bsy, dn, vv, zz, nn;
    int edges, lat;
    bit seq_ok, hold_ok, got;
    model(w, o, sg, aa, bb, elo, ehi, ev, ez, en);
    read_out(w, bsy, dn, lo0, hi0, vv, zz, nn);
    op = o; sign = sg; a = aa; b = bb;
    if (w == 8) start8 = 1'b1; else start16 = 1'b1;
    edges = -1; lat = -1; seq_ok = 1'b1; hold_ok = 1'b1; got = 1'b0;
    for (int cyc = 0; cyc < 2000 && !got; cyc++) begin
      cen = rnd_cen ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (cen) edges++;
      read_out(w, bsy, dn, lo, hi, vv, zz, nn);
      if (edges >= 0) begin
        if (dn) begin
          got = 1'b1;
          lat = edges;
          if (bsy) seq_ok = 1'b0;
        end else if (!bsy) seq_ok = 1'b0;
        if (!dn && (lo !== lo0 || hi !== hi0)) hold_ok = 1'b0;
        start8  = (w == 8)  && hammer && !got && 1'($urandom_range(0, 1));
        start16 = (w == 16) && hammer && !got && 1'($urandom_range(0, 1));
      end
    end
    start8 = 1'b0;
    start16 = 1'b0;
    check("completed", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(w + 1));
    check("busy_done_seq", 32'(seq_ok), 32'd1);
    check("result_hold", 32'(hold_ok), 32'd1);
    check("rslt_lo", 32'(lo), 32'(elo));
    check("rslt_hi", 32'(hi), 32'(ehi));
    check("flag_v", 32'(vv), 32'(ev));
    check("flag_z", 32'(zz), 32'(ez));
    check("flag_n", 32'(nn), 32'(en));
  endtask

  task automatic rand_op(input int w, input bit rnd_cen, input bit hammer);
    bit o, sg;
    logic [31:0] aa, m2;
    logic [15:0] bb, mw;
    m2 = (w == 8) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    mw = (w == 8) ? 16'h00FF : 16'hFFFF;
    o  = 1'($urandom_range(0, 1));
    sg = 1'($urandom_range(0, 1));
    aa = $urandom & m2;
    bb = 16'($urandom) & mw;
    if (o && $urandom_range(0, 3) != 0) begin
      aa = aa >> (w/2 + $urandom_range(0, w));
      if (sg && $urandom_range(0, 1) == 1) aa = (-aa) & m2;
    end
    if ($urandom_range(0, 15) == 0) bb = '0;
    run_op(w, o, sg, aa, bb, rnd_cen, hammer);
  endtask

  initial begin
    rst = 1'b1;
    cen = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_lo8", 32'(lo8), 32'd0);
    check("rst_hi8", 32'(hi8), 32'd0);
    check("rst_vzn8", 32'({v8, z8, n8}), 32'd0);
    check("rst_busy16", 32'(busy16), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed W=8 cases
    run_op(8, 1'b1, 1'b0, 32'h03E8, 16'h07, 1'b0, 1'b0);
    check("div1000_lo", 32'(lo8), 32'h8E);
    check("div1000_hi", 32'(hi8), 32'h06);
    run_op(8, 1'b1, 1'b1, 32'hFF9C, 16'h07, 1'b0, 1'b0);
    run_op(8, 1'b0, 1'b1, 32'h00FD, 16'h05, 1'b0, 1'b0);
    run_op(8, 1'b1, 1'b0, 32'h0100, 16'h00, 1'b0, 1'b0);
    check("divzero_v", 32'(v8), 32'd1);
    check("divzero_lo", 32'(lo8), 32'hFF);
    run_op(8, 1'b1, 1'b0, 32'h0800, 16'h08, 1'b0, 1'b0);
    check("divovf_hi", 32'(hi8), 32'h00);
    run_op(8, 1'b1, 1'b1, 32'hFF80, 16'h01, 1'b0, 1'b0);
    run_op(8, 1'b1, 1'b1, 32'h0080, 16'h01, 1'b0, 1'b0);
    run_op(8, 1'b1, 1'b1, 32'h8000, 16'hFF, 1'b0, 1'b0);
    run_op(8, 1'b0, 1'b0, 32'h00FF, 16'hFF, 1'b0, 1'b0);
    run_op(8, 1'b0, 1'b1, 32'h0080, 16'h80, 1'b0, 1'b0);
    run_op(8, 1'b0, 1'b0, 32'h0000, 16'h5A, 1'b0, 1'b0);

    // Random W=8, back-to-back issue
    for (int i = 0; i < 30; i++) rand_op(8, 1'b0, 1'b0);

    // W=16 with random cen and starts asserted while busy
    run_op(16, 1'b0, 1'b0, 32'h1234, 16'h5678, 1'b1, 1'b1);
    check("mul16_hi", 32'(hi16), 32'h0626);
    check("mul16_lo", 32'(lo16), 32'h0060);
    cen = 1'b0;
    repeat (3) @(negedge clk);
    check("done_frozen", 32'(done16), 32'd1);
    cen = 1'b1;
    @(negedge clk);
    check("done_cleared", 32'(done16), 32'd0);
    check("idle_busy16", 32'(busy16), 32'd0);
    for (int i = 0; i < 12; i++) rand_op(16, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a divide
    run_op(8, 1'b1, 1'b0, 32'h03E8, 16'h07, 1'b0, 1'b0);
    op = 1'b1; sign = 1'b0; a = 32'h03E8; b = 16'h07;
    start8 = 1'b1;
    cen = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(busy8), 32'd1);
    check("pre_rst_lo", 32'(lo8), 32'h8E);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy8), 32'd0);
    check("arst_done", 32'(done8), 32'd0);
    check("arst_lo", 32'(lo8), 32'd0);
    check("arst_hi", 32'(hi8), 32'd0);
    check("arst_vzn", 32'({v8, z8, n8}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(8, 1'b1, 1'b0, 32'h0064, 16'h0A, 1'b0, 1'b0);
    check("post_rst_lo", 32'(lo8), 32'h0A);
    check("post_rst_hi", 32'(hi8), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
